// File: rtl/adder_rr_sched_if.sv
// Request, response and shared-adder signal bundle for adder_rr_sched.
// slave is the scheduler side; master is the clients plus the adder.
interface adder_rr_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       Req_Valid;
    logic [NREQ*WIDTH-1:0] Req_A;
    logic [NREQ*WIDTH-1:0] Req_B;
    logic [NREQ-1:0]       Req_Ready;

    logic                  Rsp_Valid;
    logic                  Rsp_Ready;
    logic [IDW-1:0]        Rsp_Id;
    logic [WIDTH-1:0]      Rsp_Sum;
    logic                  Rsp_Overflow;

    logic [WIDTH-1:0]      Add_A;
    logic [WIDTH-1:0]      Add_B;
    logic                  Add_En;
    logic [WIDTH-1:0]      Add_Sum;
    logic                  Add_Overflow;

    logic                  Busy;

    modport master (
        output Req_Valid, Req_A, Req_B, Rsp_Ready, Add_Sum, Add_Overflow,
        input  Req_Ready, Rsp_Valid, Rsp_Id, Rsp_Sum, Rsp_Overflow,
        input  Add_A, Add_B, Add_En, Busy
    );

    modport slave (
        input  Req_Valid, Req_A, Req_B, Rsp_Ready, Add_Sum, Add_Overflow,
        output Req_Ready, Rsp_Valid, Rsp_Id, Rsp_Sum, Rsp_Overflow,
        output Add_A, Add_B, Add_En, Busy
    );
endinterface

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one registered adder among NREQ clients.
// One operation in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module adder_rr_sched #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int ADD_LATENCY = 1
) (
    input logic           Clk,
    input logic           Rst,
    adder_rr_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gid;
    logic [IDW-1:0]   pick;
    logic             found;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_ovf;
    logic             rsp_valid;

    // Walk offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (bus.Req_Valid[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (bus.Rsp_Ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr       <= '0;
            gid       <= '0;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gid   <= pick;
                        add_a <= bus.Req_A[int'(pick)*WIDTH +: WIDTH];
                        add_b <= bus.Req_B[int'(pick)*WIDTH +: WIDTH];
                    end
                end
                ISSUE: begin
                    cnt <= CW'(ADD_LATENCY - 1);
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_sum   <= bus.Add_Sum;
                        rsp_ovf   <= bus.Add_Overflow;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.Rsp_Ready) begin
                        rsp_valid <= 1'b0;
                        ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Req_Ready = (state == IDLE && found && !Rst)
                         ? (NREQ'(1) << pick) : '0;
    assign bus.Add_En       = (state == ISSUE);
    assign bus.Add_A        = add_a;
    assign bus.Add_B        = add_b;
    assign bus.Rsp_Valid    = rsp_valid;
    assign bus.Rsp_Id       = gid;
    assign bus.Rsp_Sum      = rsp_sum;
    assign bus.Rsp_Overflow = rsp_ovf;
    assign bus.Busy         = (state != IDLE);
endmodule
